// File: rtl/alu_seq_muldiv_pkg.sv
// Shared definitions for the sequential mul/div ALU.
// Provides the 4-bit ALU op-code constants and the 2-bit state encoding
// used by the iterative multiply/divide FSM.
package alu_defs;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_NOR   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_LUI   = 4'd7;
  localparam logic [3:0] OP_BEQ   = 4'd8;
  localparam logic [3:0] OP_BNE   = 4'd9;
  localparam logic [3:0] OP_MULTU = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_MFHI  = 4'd12;
  localparam logic [3:0] OP_MFLO  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/alu_seq_muldiv_if.sv
// ALU request/result bundle.
// master: execute-stage control (drives op, operands, start).
// slave : the ALU (drives ALUResult, Zero, busy, done, HI, LO).
interface alu_seq_muldiv_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               start;
  logic [3:0]         ALUOperation;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   ALUResult;
  logic               Zero;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   HI;
  logic [WIDTH-1:0]   LO;

  modport master (
    output start, ALUOperation, A, B, shamt,
    input  ALUResult, Zero, busy, done, HI, LO
  );

  modport slave (
    input  start, ALUOperation, A, B, shamt,
    output ALUResult, Zero, busy, done, HI, LO
  );
endinterface

// File: rtl/alu_seq_muldiv_muldiv.sv
// Iterative unsigned multiply / restoring divide unit.
// Ports: clk, reset (async, active low), start, op, a, b in;
//        hi, lo, busy, done out.
// One iteration per cycle for WIDTH cycles, then one DONE cycle.
// HI/LO are only written on the edge that enters DONE.
module alu_muldiv_iter
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  // mul: {partial product, remaining multiplier bits}
  // div: {partial remainder, dividend bits / quotient bits}
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    // Remainder shifted left with the next dividend bit; the extra top bit
    // keeps the compare exact when the remainder's MSB is set.
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    acc_nxt  = acc;
    if (is_div) begin
      if (rem_sh >= {1'b0, b_q})
        acc_nxt = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (op == OP_MULTU || op == OP_DIVU)) begin
            a_q    <= a;
            b_q    <= b;
            is_div <= (op == OP_DIVU);
            cnt    <= '0;
            acc    <= (op == OP_DIVU) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            hi    <= acc_nxt[2*WIDTH-1:WIDTH];
            lo    <= acc_nxt[WIDTH-1:0];
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: rtl/alu_seq_muldiv.sv
// Execute-stage ALU with iterative MULTU/DIVU into HI/LO.
// Ports: clk, reset (async, active low), bus (slave modport of
// alu_seq_muldiv_if: start, ALUOperation, A, B, shamt in;
// ALUResult, Zero, busy, done, HI, LO out).
// Single-cycle ops are purely combinational; MULTU/DIVU report 0 on
// ALUResult and deliver their result through HI/LO.
module alu_seq_muldiv
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_muldiv_if.slave bus
);
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .reset (reset),
    .start (bus.start),
    .op    (bus.ALUOperation),
    .a     (bus.A),
    .b     (bus.B),
    .hi    (hi),
    .lo    (lo),
    .busy  (bus.busy),
    .done  (bus.done)
  );

  always_comb begin
    res = '0;
    case (bus.ALUOperation)
      OP_AND:  res = bus.A & bus.B;
      OP_OR:   res = bus.A | bus.B;
      OP_NOR:  res = ~(bus.A | bus.B);
      OP_ADD:  res = bus.A + bus.B;
      OP_SUB:  res = bus.A - bus.B;
      OP_SRL:  res = bus.B >> bus.shamt;
      OP_SLL:  res = bus.B << bus.shamt;
      OP_LUI:  res = bus.B << (WIDTH / 2);
      OP_BEQ:  res = (bus.A == bus.B) ? '0 : WIDTH'(1);
      OP_BNE:  res = (bus.A != bus.B) ? '0 : WIDTH'(1);
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      default: res = '0;
    endcase
  end

  assign bus.ALUResult = res;
  assign bus.Zero      = (res == '0);
  assign bus.HI        = hi;
  assign bus.LO        = lo;

endmodule
